// File: rtl/onchip_copy_pkg.sv
// Shared defaults, FSM state type and byteenable constant for the on-chip memory copy master.
package onchip_copy_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic [DEF_DATA_W/8-1:0] BE_ALL = '1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } copy_state_e;

endpackage

// File: rtl/onchip_copy_addr_gen.sv
// Source/destination pointers, copy direction and remaining word count for the copy master.
module onchip_copy_addr_gen
    import onchip_copy_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [ADDR_W:0]   length_i,
    output logic [ADDR_W-1:0] src_ptr_o,
    output logic [ADDR_W-1:0] dst_ptr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic              desc_q, desc_d;

    always_comb begin
        src_d    = src_q;
        dst_d    = dst_q;
        desc_d   = desc_q;
        remain_d = remain_q;
        span     = ADDR_W'(length_i - (ADDR_W+1)'(1));
        if (load_i) begin
            desc_d   = dst_addr_i > src_addr_i;
            remain_d = length_i;
            if (desc_d) begin
                src_d = src_addr_i + span;
                dst_d = dst_addr_i + span;
            end else begin
                src_d = src_addr_i;
                dst_d = dst_addr_i;
            end
        end else if (step_i) begin
            remain_d = remain_q - (ADDR_W+1)'(1);
            if (desc_q) begin
                src_d = src_q - ADDR_W'(1);
                dst_d = dst_q - ADDR_W'(1);
            end else begin
                src_d = src_q + ADDR_W'(1);
                dst_d = dst_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q    <= '0;
            dst_q    <= '0;
            desc_q   <= 1'b0;
            remain_q <= '0;
        end else begin
            src_q    <= src_d;
            dst_q    <= dst_d;
            desc_q   <= desc_d;
            remain_q <= remain_d;
        end
    end

    // Look-ahead pointers let the top register the bus address in the same edge as the load/step.
    assign src_ptr_o = src_d;
    assign dst_ptr_o = dst_d;
    assign last_o    = remain_q == (ADDR_W+1)'(1);

endmodule

// File: rtl/onchip_mem_copy_master.sv
// Avalon-MM block copy initiator for the single-port on-chip RAM (RD/CAP/WR per word).
// Optional ONCHIP_COPY_CHECKSUM_EN adds a running sum of every written word.
module onchip_mem_copy_master
    import onchip_copy_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [ADDR_W:0]     length,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                chipselect,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic                clken,
`ifdef ONCHIP_COPY_CHECKSUM_EN
    output logic [DATA_W-1:0]   checksum,
`endif
    input  logic [DATA_W-1:0]   readdata
);

    copy_state_e state_q, state_d;

    logic              load, step, last;
    logic [ADDR_W-1:0] src_ptr, dst_ptr;

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cs_q, cs_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W/8-1:0] be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    onchip_copy_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .load_i     (load),
        .step_i     (step),
        .src_addr_i (src_addr),
        .dst_addr_i (dst_addr),
        .length_i   (length),
        .src_ptr_o  (src_ptr),
        .dst_ptr_o  (dst_ptr),
        .last_o     (last)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_d = DONE;
                    end else begin
                        load    = 1'b1;
                        state_d = RD;
                    end
                end
            end
            RD:   state_d = CAP;
            CAP:  state_d = WR;
            WR: begin
                step    = 1'b1;
                state_d = last ? DONE : RD;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with the state they belong to.
    always_comb begin
        busy_d    = state_d != IDLE;
        done_d    = state_d == DONE;
        cs_d      = (state_d == RD) || (state_d == WR);
        write_d   = state_d == WR;
        be_d      = cs_d ? BE_ALL : '0;
        address_d = address_q;
        if (state_d == RD) begin
            address_d = src_ptr;
        end else if (state_d == WR) begin
            address_d = dst_ptr;
        end
        wdata_d = (state_q == CAP) ? readdata : wdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_q      <= 1'b0;
            write_q   <= 1'b0;
            address_q <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cs_q      <= cs_d;
            write_q   <= write_d;
            address_q <= address_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
        end
    end

`ifdef ONCHIP_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == IDLE && start) begin
            csum_d = '0;
        end else if (state_q == WR) begin
            csum_d = csum_q + wdata_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign chipselect = cs_q;
    assign write      = write_q;
    assign address    = address_q;
    assign byteenable = be_q;
    assign writedata  = wdata_q;
    assign clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// Scoreboard bench: memmove reference model predicts bus ops, done timing and final memory image.
module tb_onchip_mem_copy_master;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b1;
    logic          start    = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   length   = '0;
    logic          busy, done, chipselect, write, clken;
    logic [AW-1:0] address;
    logic [DW/8-1:0] byteenable;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata = '0;
`ifdef ONCHIP_COPY_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    onchip_mem_copy_master #(
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .address    (address),
        .byteenable (byteenable),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .clken      (clken),
`ifdef ONCHIP_COPY_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .readdata   (readdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // On-chip RAM model with one-cycle read latency plus a bench preload port.
    logic [DW-1:0] mem [DEPTH];
    logic          tb_we    = 1'b0;
    logic [AW-1:0] tb_waddr = '0;
    logic [DW-1:0] tb_wdata = '0;

    always @(posedge clk) begin
        if (tb_we) begin
            mem[tb_waddr] <= tb_wdata;
        end else if (chipselect && clken) begin
            if (write) mem[address] <= writedata;
            else       readdata     <= mem[address];
        end
    end

    typedef struct { bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; } op_t;
    typedef struct { int unsigned cyc; int unsigned busy_len; logic [DW-1:0] csum; } done_t;
    typedef struct { string name; logic [63:0] got; logic [63:0] exp; } chk_t;

    op_t   exp_ops[$];
    done_t exp_done[$];
    chk_t  chk_q[$];

    logic [DW-1:0] ref_mem [DEPTH];
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned done_seen = 0;
    int unsigned exp_dones = 0;

    function automatic logic [AW-1:0] wrap(input int v);
        return AW'(v);
    endfunction

    function automatic int mem_mismatch();
        int n = 0;
        for (int a = 0; a < DEPTH; a++) if (mem[a] !== ref_mem[a]) n++;
        return n;
    endfunction

    task automatic post(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_t c;
        c.name = name;
        c.got  = got;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    // Monitor: every comparison is counted here.
    initial begin
        op_t         op;
        done_t       d;
        chk_t        c;
        int unsigned busy_run = 0;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                total++;
                if (c.got !== c.exp) begin
                    bad++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, c.got, c.exp);
                end
            end
            if (!reset_n) begin
                busy_run = 0;
            end else begin
                if (busy) busy_run++;
                if (chipselect) begin
                    total++;
                    if (exp_ops.size() == 0) begin
                        bad++;
                        $display("FAIL bus_unexpected: got addr=%0d wr=%0b expected no access", address, write);
                    end else begin
                        op = exp_ops.pop_front();
                        if (address !== op.addr || write !== op.wr || byteenable !== '1 ||
                            (op.wr && writedata !== op.data)) begin
                            bad++;
                            $display("FAIL bus_op: got addr=%0d wr=%0b be=%h data=%h expected addr=%0d wr=%0b be=f data=%h",
                                     address, write, byteenable, writedata, op.addr, op.wr, op.data);
                        end
                    end
                end
                if (done) begin
                    done_seen++;
                    total++;
                    if (exp_done.size() == 0) begin
                        bad++;
                        $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
                    end else begin
                        d = exp_done.pop_front();
                        if (cyc !== d.cyc || busy_run !== d.busy_len) begin
                            bad++;
                            $display("FAIL done_timing: got cycle=%0d busy_cycles=%0d expected cycle=%0d busy_cycles=%0d",
                                     cyc, busy_run, d.cyc, d.busy_len);
                        end
`ifdef ONCHIP_COPY_CHECKSUM_EN
                        total++;
                        if (checksum !== d.csum) begin
                            bad++;
                            $display("FAIL checksum: got %h expected %h", checksum, d.csum);
                        end
`endif
                    end
                    busy_run = 0;
                end
            end
        end
    end

    task automatic poke(input int a, input logic [DW-1:0] v);
        tb_we    = 1'b1;
        tb_waddr = wrap(a);
        tb_wdata = v;
        ref_mem[a] = v;
        @(posedge clk);
        #1;
        tb_we = 1'b0;
    endtask

    // Reference: memmove of len words, direction by dst>src, first ncommit words land in ref_mem.
    task automatic issue(input int src, input int dst, input int len, input int ncommit,
                         input bit immediate, output int unsigned st);
        logic [DW-1:0] tmp[$];
        logic [DW-1:0] sum;
        done_t d;
        int o;
        if (!immediate) begin
            @(posedge clk);
            #1;
        end
        st  = cyc;
        sum = '0;
        tmp = {};
        for (int i = 0; i < len; i++) tmp.push_back(ref_mem[wrap(src + i)]);
        for (int k = 0; k < len; k++) begin
            o = (dst > src) ? len - 1 - k : k;
            exp_ops.push_back('{wr: 1'b0, addr: wrap(src + o), data: '0});
            exp_ops.push_back('{wr: 1'b1, addr: wrap(dst + o), data: tmp[o]});
            sum += tmp[o];
            if (k < ncommit) ref_mem[wrap(dst + o)] = tmp[o];
        end
        d.cyc      = st + 3 * len + 1;
        d.busy_len = 3 * len + 1;
        d.csum     = sum;
        exp_done.push_back(d);
        exp_dones++;
        src_addr = wrap(src);
        dst_addr = wrap(dst);
        length   = (AW+1)'(len);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        src_addr = AW'($urandom);
        dst_addr = AW'($urandom);
        length   = (AW+1)'($urandom);
    endtask

    task automatic wait_done(input int len);
        int n = 0;
        while (done_seen < exp_dones && n < 3 * len + 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        post("done_arrived", 64'(done_seen >= exp_dones), 64'd1);
        post("ops_drained", 64'(exp_ops.size()), 64'd0);
        post("mem_contents", 64'(mem_mismatch()), 64'd0);
        post("idle_after_done", {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        int unsigned st;
        int src, dst, len;

        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        post("reset_outputs", 64'({busy, done, chipselect, write, address, byteenable, writedata, clken}), 64'd1);
        reset_n = 1'b1;

        for (int a = 0; a < DEPTH; a++) poke(a, $urandom);

        // Ascending copy, done at start+13
        poke(0, 32'h11); poke(1, 32'h22); poke(2, 32'h33); poke(3, 32'h44);
        issue(0, 100, 4, 4, 1'b0, st);
        wait_done(4);

        // Overlapping, dst > src -> descending
        for (int i = 0; i < 5; i++) poke(10 + i, DW'(i + 1));
        issue(10, 12, 5, 5, 1'b0, st);
        wait_done(5);

        // Source wraps past the top of memory
        issue(1022, 500, 4, 4, 1'b0, st);
        wait_done(4);

        // Zero length: done after one cycle, no bus access
        issue(5, 6, 0, 0, 1'b0, st);
        wait_done(0);

        // Same source and destination still does a full pass
        issue(50, 50, 3, 3, 1'b0, st);
        wait_done(3);

        // Start while busy is ignored
        issue(300, 400, 6, 6, 1'b0, st);
        repeat (4) @(posedge clk);
        #1;
        src_addr = 10'd0;
        dst_addr = 10'd900;
        length   = 11'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(6);

        // Checksum wrap case
        poke(600, 32'hFFFF_FFFF);
        poke(601, 32'h0000_0002);
        issue(600, 700, 2, 2, 1'b0, st);
        wait_done(2);

        // Reset during WR of word 2 of 8: only words 0..1 land
        issue(200, 300, 8, 2, 1'b0, st);
        while (cyc < st + 9) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        post("reset_midcopy_outputs",
             64'({busy, done, chipselect, write, address, byteenable, writedata, clken}), 64'd1);
        exp_ops.delete();
        exp_done.delete();
        exp_dones = done_seen;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        post("mem_after_reset", 64'(mem_mismatch()), 64'd0);

        issue(200, 300, 8, 8, 1'b0, st);
        wait_done(8);

        // Random copies, some overlapping, some back-to-back in the cycle after done
        for (int t = 0; t < 40; t++) begin
            len = $urandom_range(0, 16);
            src = $urandom_range(0, DEPTH - len);
            if ($urandom_range(0, 2) == 0) begin
                dst = src + int'($urandom_range(0, 8)) - 4;
                if (dst < 0) dst = 0;
                if (dst > DEPTH - len) dst = DEPTH - len;
            end else begin
                dst = $urandom_range(0, DEPTH - len);
            end
            issue(src, dst, len, len, $urandom_range(0, 1) == 1, st);
            wait_done(len);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/onchip_mem_copy_master.md
# onchip_mem_copy_master

Avalon-MM initiator that copies a block of 32-bit words between two regions of the 1024×32 single-port on-chip memory, driving its s1 slave port directly. It sits beside the Nios II data master on the same memory so firmware can offload block moves such as UART buffer shuffles. Reads use the memory's fixed one-cycle read latency. Direction is chosen automatically, so overlapping regions copy correctly.

## Interface
- ADDR_W, 10, word-address width; memory depth is 2**ADDR_W.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- src_addr  in  ADDR_W  first source word address.
- dst_addr  in  ADDR_W  first destination word address.
- length  in  ADDR_W+1  word count, 0..1024.
- busy  out  1  high from the cycle after an accepted start through the DONE state.
- done  out  1  one-cycle pulse when a copy completes.
- address  out  ADDR_W  memory word address.
- byteenable  out  DATA_W/8  all ones during reads and writes, otherwise 0.
- chipselect  out  1  memory select.
- write  out  1  write strobe; qualified by chipselect.
- writedata  out  DATA_W  data to write.
- clken  out  1  tied high.
- readdata  in  DATA_W  memory read data, valid the cycle after a read.

## Operation
- States are IDLE, RD, CAP, WR and DONE.
- IDLE:
  - If start=1 and length=0, go to DONE.
  - If start=1 and length>0, latch src, dst and length, and compute direction.
  - Direction is descending if dst_addr > src_addr, else ascending.
  - For a descending copy, load pointers to src+len-1 and dst+len-1, modulo 2**ADDR_W.
  - Then go to RD.
- RD: drive address=src pointer, chipselect=1, write=0; go to CAP.
- CAP: register readdata into the data holding register; chipselect=0; go to WR.
- WR: drive address=dst pointer, chipselect=1, write=1, writedata=held data.
  - Step both pointers by +1 (ascending) or −1 (descending), wrapping modulo 2**ADDR_W.
  - Decrement the remaining count; if the new count is 0 go to DONE, else go to RD.
- DONE: done=1 for exactly one cycle, then IDLE.
- start while busy is ignored and never queued.
- src_addr = dst_addr runs a full read/write pass, with no shortcut.
- Pointer arithmetic and wrap:
  - Pointers are ADDR_W bits; wrap from 1023 to 0 is silent.
  - The remaining-count register is ADDR_W+1 bits.
- Reset (including mid-copy):
  - State returns to IDLE and all outputs go to their reset values.
  - A partially copied region is left as-is; no memory write is issued in the reset cycle.

## Timing
- Reset values: busy=0, done=0, chipselect=0, write=0, address=0, byteenable=0, writedata=0, clken=1.
- Outputs are registered; memory signals change only on clk edges.
- Per word: 3 cycles (RD, CAP, WR).
- Length N>0: done asserts 3N+1 cycles after the start cycle.
- Length 0: done asserts 1 cycle after the start cycle.
- A new start is accepted in the cycle done is high + 1 (IDLE).
- readdata is sampled only in CAP, i.e. one cycle after the RD address was presented.

## Configuration
- ONCHIP_COPY_CHECKSUM_EN:
  - When defined, adds output checksum (DATA_W): the modulo-2**DATA_W sum of every word written.
  - checksum clears on an accepted start, updates in each WR, and is stable from done until the next start.
  - When undefined, the port and the accumulator are absent; all other behaviour and timing are identical.

## Structure
- Package onchip_copy_pkg holds:
  - ADDR_W and DATA_W defaults;
  - the state enum type (IDLE, RD, CAP, WR, DONE);
  - the BE_ALL constant (all-ones byteenable).
- Sub-module onchip_copy_addr_gen holds the two pointers, the direction flag, wrap arithmetic and the remaining-count register.
  - Its inputs are load, step and the start fields; its outputs are src_ptr, dst_ptr and last.
  - The FSM stays in the top level.

## Test plan
- Ascending copy: mem[0..3]=0x11,0x22,0x33,0x44; start src=0 dst=100 len=4 -> mem[100..103] match, done at cycle 13, busy high cycles 1..13.
- Overlap, dst>src: mem[10..14]=1..5; src=10 dst=12 len=5 -> descending copy, mem[12..16]=1..5.
- Wrap: src=1022 dst=500 len=4 -> reads addresses 1022,1023,0,1; writes 500..503.
- Length 0 and busy-start:
  - len=0 -> done one cycle later, with no chipselect ever asserted.
  - start pulsed mid-copy -> ignored; single done.
- Reset mid-copy: assert reset_n=0 during the WR of word 2 of 8 -> outputs at reset values immediately, only words 0..1 (or 0..2) written, a fresh copy succeeds afterward.
- With ONCHIP_COPY_CHECKSUM_EN: copy words 0xFFFFFFFF,0x00000002 -> checksum=0x00000001 at done.
